// File: rtl/add32_sched.sv
// rtl/add32_sched.sv - round-robin scheduler sequencing multi-word adds through a shared 32-bit adder
// Transactions are granted whole; the carry chains between beats of the owning requester.
module add32_sched #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req0_last,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  input  logic         req1_last,
  output logic         resp0_valid,
  output logic [W-1:0] resp0_sum,
  output logic         resp0_cout,
  output logic         resp1_valid,
  output logic [W-1:0] resp1_sum,
  output logic         resp1_cout,
  output logic         add_adv,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_result,
  input  logic         add_c8
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state;
  logic   prio;
  logic   cy;
  logic   acc0;
  logic   acc1;

  // Grant: contention in IDLE resolved by prio; a locked owner is always ready.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          req0_ready = req0_valid & (~req1_valid | ~prio);
          req1_ready = req1_valid & (~req0_valid |  prio);
        end
        LOCK0:   req0_ready = 1'b1;
        LOCK1:   req1_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;

  // First beat of a transaction takes its own cin; later beats take the chained carry.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_adv = 1'b0;
    if (acc0) begin
      add_a   = req0_a;
      add_b   = req0_b;
      add_adv = (state == IDLE) ? req0_cin : cy;
    end else if (acc1) begin
      add_a   = req1_a;
      add_b   = req1_b;
      add_adv = (state == IDLE) ? req1_cin : cy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      cy          <= 1'b0;
      resp0_valid <= 1'b0;
      resp0_sum   <= '0;
      resp0_cout  <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_sum   <= '0;
      resp1_cout  <= 1'b0;
    end else begin
      resp0_valid <= acc0;
      resp1_valid <= acc1;
      if (acc0) begin
        resp0_sum  <= add_result;
        resp0_cout <= add_c8;
        if (req0_last) begin
          state <= IDLE;
          prio  <= 1'b1;
        end else begin
          state <= LOCK0;
          cy    <= add_c8;
        end
      end
      if (acc1) begin
        resp1_sum  <= add_result;
        resp1_cout <= add_c8;
        if (req1_last) begin
          state <= IDLE;
          prio  <= 1'b0;
        end else begin
          state <= LOCK1;
          cy    <= add_c8;
        end
      end
    end
  end

endmodule

// File: tb/tb_add32_sched.sv
// tb/tb_add32_sched.sv - directed and random bench for add32_sched
// The shared adder beside the scheduler is modelled here as a plain combinational add.
module tb_add32_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin, req0_last;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin, req1_last;
  logic [31:0] req1_a, req1_b;
  logic        resp0_valid, resp0_cout, resp1_valid, resp1_cout;
  logic [31:0] resp0_sum, resp1_sum;
  logic        add_adv, add_c8;
  logic [31:0] add_a, add_b, add_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_c8, add_result} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_adv};

  add32_sched #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_last(req1_last),
    .resp0_valid(resp0_valid), .resp0_sum(resp0_sum), .resp0_cout(resp0_cout),
    .resp1_valid(resp1_valid), .resp1_sum(resp1_sum), .resp1_cout(resp1_cout),
    .add_adv(add_adv), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_c8(add_c8)
  );

  task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic last);
    if (r == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; req0_last = last;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; req1_last = last;
    end
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 32'd9, 32'd9, 1'b1, 1'b1);
    set_req(1, 1'b1, 32'd3, 32'd3, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({resp0_valid, resp0_cout, resp0_sum, resp1_valid, resp1_cout, resp1_sum} !== 68'd0) begin
      errors++; $display("FAIL reset_resp: got v0=%b s0=%h v1=%b s1=%h expected all zero",
                         resp0_valid, resp0_sum, resp1_valid, resp1_sum);
    end
    checks++;
    if ({add_adv, add_a, add_b} !== 65'd0) begin
      errors++; $display("FAIL reset_adder: got a=%h b=%h adv=%b expected 0", add_a, add_b, add_adv);
    end
    idle_all();
  endtask

  task automatic test_single();
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
    #1;
    checks++;
    if ({req0_ready, add_adv, add_a} !== {1'b1, 1'b1, 32'd5}) begin
      errors++; $display("FAIL single_grant: got rdy=%b adv=%b a=%h expected 1 1 5", req0_ready, add_adv, add_a);
    end
    @(negedge clk);
    idle_all();
    checks++;
    if ({resp0_valid, resp0_cout, resp0_sum, resp1_valid} !== {1'b1, 1'b0, 32'd13, 1'b0}) begin
      errors++; $display("FAIL single_resp: got v=%b c=%b s=%h v1=%b expected 1 0 d 0",
                         resp0_valid, resp0_cout, resp0_sum, resp1_valid);
    end
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp0_sum} !== {1'b0, 32'd13}) begin
      errors++; $display("FAIL single_hold: got v=%b s=%h expected 0 d", resp0_valid, resp0_sum);
    end
  endtask

  task automatic test_two_beat();
    @(negedge clk);
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp0_cout, resp0_sum} !== {1'b1, 1'b1, 32'd0}) begin
      errors++; $display("FAIL two_beat0: got v=%b c=%b s=%h expected 1 1 0", resp0_valid, resp0_cout, resp0_sum);
    end
    set_req(0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp0_cout, resp0_sum} !== {1'b1, 1'b0, 32'd1}) begin
      errors++; $display("FAIL two_beat1: got v=%b c=%b s=%h expected 1 0 1", resp0_valid, resp0_cout, resp0_sum);
    end
    // chained carry is 0 here, so a leaked cin=1 would show as 9
    set_req(0, 1'b1, 32'd1, 32'd1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp0_cout, resp0_sum} !== {1'b1, 1'b0, 32'd3}) begin
      errors++; $display("FAIL cin_beat0: got v=%b c=%b s=%h expected 1 0 3", resp0_valid, resp0_cout, resp0_sum);
    end
    set_req(0, 1'b1, 32'd4, 32'd4, 1'b1, 1'b1);
    @(negedge clk);
    idle_all();
    checks++;
    if ({resp0_valid, resp0_sum} !== {1'b1, 32'd8}) begin
      errors++; $display("FAIL cin_ignored: got v=%b s=%h expected 1 8", resp0_valid, resp0_sum);
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        checks++;
        if ((i - 1) % 2 == 0) begin
          if ({resp0_valid, resp0_sum, resp1_valid} !== {1'b1, 32'h30, 1'b0}) begin
            errors++; $display("FAIL contend_resp%0d: got v0=%b s0=%h v1=%b expected 1 30 0",
                               i - 1, resp0_valid, resp0_sum, resp1_valid);
          end
        end else begin
          if ({resp1_valid, resp1_sum, resp0_valid} !== {1'b1, 32'h301, 1'b0}) begin
            errors++; $display("FAIL contend_resp%0d: got v1=%b s1=%h v0=%b expected 1 301 0",
                               i - 1, resp1_valid, resp1_sum, resp0_valid);
          end
        end
      end
      if (i == 4) break;
      set_req(0, 1'b1, 32'h10, 32'h20, 1'b0, 1'b1);
      set_req(1, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1);
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL contend_grant%0d: got %b expected %b", i,
                           {req0_ready, req1_ready}, ((i % 2 == 0) ? 2'b10 : 2'b01));
      end
      @(negedge clk);
    end
    idle_all();
  endtask

  task automatic test_stall();
    @(negedge clk);
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    set_req(1, 1'b1, 32'd3, 32'd4, 1'b0, 1'b1);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL stall_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp0_cout, resp0_sum} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL stall_beat0: got v=%b c=%b s=%h expected 1 1 ffffffff",
                         resp0_valid, resp0_cout, resp0_sum);
    end
    req0_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        errors++; $display("FAIL stall_lock%0d: got %b expected 10", s, {req0_ready, req1_ready});
      end
      @(negedge clk);
      checks++;
      if ({resp0_valid, resp1_valid} !== 2'b00) begin
        errors++; $display("FAIL stall_noresp%0d: got %b expected 00", s, {resp0_valid, resp1_valid});
      end
    end
    set_req(0, 1'b1, 32'd1, 32'd2, 1'b0, 1'b1);
    #1;
    checks++;
    if (add_adv !== 1'b1) begin
      errors++; $display("FAIL stall_carry: got adv=%b expected 1", add_adv);
    end
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp0_cout, resp0_sum} !== {1'b1, 1'b0, 32'd4}) begin
      errors++; $display("FAIL stall_beat1: got v=%b c=%b s=%h expected 1 0 4", resp0_valid, resp0_cout, resp0_sum);
    end
    req0_valid = 1'b0;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL stall_handoff: got rdy1=%b expected 1", req1_ready);
    end
    @(negedge clk);
    idle_all();
    checks++;
    if ({resp1_valid, resp1_sum} !== {1'b1, 32'd7}) begin
      errors++; $display("FAIL stall_req1: got v=%b s=%h expected 1 7", resp1_valid, resp1_sum);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] a;
    logic [32:0] exp_prev;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k > 1) begin
        checks++;
        if ({resp1_valid, resp1_cout, resp1_sum} !== {1'b1, exp_prev}) begin
          errors++; $display("FAIL sweep_nib%0d: got v=%b c=%b s=%h expected 1 %h",
                             k - 1, resp1_valid, resp1_cout, resp1_sum, exp_prev);
        end
      end
      if (k == 9) break;
      a = (k == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * k)) - 32'd1);
      exp_prev = {1'b0, a} + 33'd1;
      set_req(1, 1'b1, a, 32'd1, 1'b0, 1'b1);
    end
    idle_all();
  endtask

  task automatic test_random();
    logic        pend;
    int          pend_r;
    logic [32:0] pend_exp;
    logic [32:0] e;
    logic [31:0] a, b;
    logic        carry;
    int          r, nb;
    pend = 1'b0;
    pend_r = 0;
    pend_exp = '0;
    for (int t = 0; t < 1000; t++) begin
      r = $urandom_range(0, 1);
      nb = $urandom_range(1, 4);
      carry = 1'($urandom_range(0, 1));
      for (int j = 0; j < nb; j++) begin
        @(negedge clk);
        if (pend) begin
          checks++;
          if (pend_r == 0 ? ({resp0_valid, resp0_cout, resp0_sum, resp1_valid} !== {1'b1, pend_exp, 1'b0})
                          : ({resp1_valid, resp1_cout, resp1_sum, resp0_valid} !== {1'b1, pend_exp, 1'b0})) begin
            errors++; $display("FAIL rand_t%0d_b%0d: got v0=%b s0=%h c0=%b v1=%b s1=%h c1=%b expected r%0d %h",
                               t, j, resp0_valid, resp0_sum, resp0_cout, resp1_valid, resp1_sum, resp1_cout,
                               pend_r, pend_exp);
          end
        end
        a = $urandom;
        b = $urandom;
        idle_all();
        set_req(r, 1'b1, a, b, (j == 0) ? carry : 1'($urandom_range(0, 1)), j == nb - 1);
        e = {1'b0, a} + {1'b0, b} + {32'd0, carry};
        carry = e[32];
        pend = 1'b1;
        pend_r = r;
        pend_exp = e;
      end
    end
    @(negedge clk);
    idle_all();
    checks++;
    if (pend_r == 0 ? ({resp0_valid, resp0_cout, resp0_sum} !== {1'b1, pend_exp})
                    : ({resp1_valid, resp1_cout, resp1_sum} !== {1'b1, pend_exp})) begin
      errors++; $display("FAIL rand_final: got v0=%b s0=%h v1=%b s1=%h expected r%0d %h",
                         resp0_valid, resp0_sum, resp1_valid, resp1_sum, pend_r, pend_exp);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_grant: got rdy1=%b expected 1", req1_ready);
    end
    @(negedge clk);
    checks++;
    if ({resp1_valid, resp1_cout, resp1_sum} !== {1'b1, 1'b1, 32'd0}) begin
      errors++; $display("FAIL midrst_beat0: got v=%b c=%b s=%h expected 1 1 0", resp1_valid, resp1_cout, resp1_sum);
    end
    rst = 1'b1;
    set_req(1, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
    #1;
    checks++;
    if ({req1_ready, add_a} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL midrst_block: got rdy1=%b a=%h expected 0 0", req1_ready, add_a);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({resp1_valid, resp1_cout, resp1_sum} !== 34'd0) begin
      errors++; $display("FAIL midrst_drop: got v=%b c=%b s=%h expected 0 0 0", resp1_valid, resp1_cout, resp1_sum);
    end
    set_req(0, 1'b1, 32'd1, 32'd1, 1'b0, 1'b1);
    set_req(1, 1'b1, 32'd7, 32'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({req0_ready, req1_ready, add_adv} !== 3'b100) begin
      errors++; $display("FAIL midrst_idle: got rdy0=%b rdy1=%b adv=%b expected 1 0 0",
                         req0_ready, req1_ready, add_adv);
    end
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp0_sum, resp1_valid} !== {1'b1, 32'd2, 1'b0}) begin
      errors++; $display("FAIL midrst_req0: got v0=%b s0=%h v1=%b expected 1 2 0", resp0_valid, resp0_sum, resp1_valid);
    end
    req0_valid = 1'b0;
    @(negedge clk);
    idle_all();
    checks++;
    if ({resp1_valid, resp1_sum} !== {1'b1, 32'd7}) begin
      errors++; $display("FAIL midrst_req1: got v=%b s=%h expected 1 7", resp1_valid, resp1_sum);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_two_beat();
    test_contention();
    test_stall();
    test_sweep();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
